// File: rtl/accum_mult_mod_pkg.sv
// Shared types and default sizing for the accum_mult_mod reduction-RAM loader.
package accum_mult_mod_pkg;

   localparam int RAM_A_W_DEF  = 8;
   localparam int RAM_D_W_DEF  = 32;
   localparam int NUM_RAMS_DEF = 12;
   localparam int DEPTH_DEF    = 2 ** RAM_A_W_DEF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEL,
      ST_WRITE,
      ST_DONE
   } ldr_state_e;

   // Sub-phases of WRITE: accept source words, pad after early i_last,
   // let the final strobe drain, then hold one idle cycle before the next select.
   typedef enum logic [1:0] {
      PH_XFER,
      PH_PAD,
      PH_FLUSH,
      PH_GAP
   } ldr_phase_e;

   function automatic int depth_of(input int aw);
      return 2 ** aw;
   endfunction

endpackage

// File: rtl/accum_mult_mod_ram_loader_if.sv
// Source stream (val/rdy/dat/last) and reduction-RAM load bus (ram_d/we/se).
interface accum_mult_mod_ram_loader_if #(
   parameter int RAM_D_W = 32
);
   logic               val;
   logic               rdy;
   logic [RAM_D_W-1:0] dat;
   logic               last;
   logic [RAM_D_W-1:0] ram_d;
   logic               ram_we;
   logic               ram_se;

   // master: the loader itself
   modport master (
      input  val, dat, last,
      output rdy, ram_d, ram_we, ram_se
   );

   // slave: host/DMA source plus multiplier-side receiver
   modport slave (
      output val, dat, last,
      input  rdy, ram_d, ram_we, ram_se
   );
endinterface

// File: rtl/accum_mult_mod_ram_loader.sv
// Frames a val/rdy stream of reduction-table words into NUM_RAMS tables of
// 2**RAM_A_W words on the ram_d/ram_we/ram_se bus toward the multiplier.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for i_start, o_rdy low
// ST_SEL   | o_ram_se pulse, receiver moves to next RAM at address 0
// ST_WRITE | accept/pad words, then drain and one idle cycle
// ST_DONE  | o_done pulse, o_busy drops next cycle
module accum_mult_mod_ram_loader
   import accum_mult_mod_pkg::*;
#(
   parameter int RAM_A_W  = RAM_A_W_DEF,
   parameter int RAM_D_W  = RAM_D_W_DEF,
   parameter int NUM_RAMS = NUM_RAMS_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
   output logic o_busy,
   output logic o_done,
   output logic o_err,
   accum_mult_mod_ram_loader_if.master bus
);

   localparam int                  TCNT_W    = $clog2(NUM_RAMS + 1);
   localparam logic [TCNT_W-1:0]   TCNT_LAST = TCNT_W'(NUM_RAMS - 1);
   localparam logic [RAM_A_W-1:0]  WCNT_LAST = RAM_A_W'(depth_of(RAM_A_W) - 1);

   ldr_state_e          r_state;
   ldr_phase_e          r_phase;
   logic [RAM_A_W-1:0]  r_wcnt;
   logic [TCNT_W-1:0]   r_tcnt;
   logic                r_rdy;
   logic [RAM_D_W-1:0]  r_ram_d;
   logic                r_ram_we;
   logic                r_ram_se;
   logic                r_busy;
   logic                r_done;
   logic                r_err;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state  <= ST_IDLE;
         r_phase  <= PH_XFER;
         r_wcnt   <= '0;
         r_tcnt   <= '0;
         r_rdy    <= 1'b0;
         r_ram_d  <= '0;
         r_ram_we <= 1'b0;
         r_ram_se <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_ram_se <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_ram_we <= 1'b0;
               r_rdy    <= 1'b0;
               if (i_start) begin
                  r_state  <= ST_SEL;
                  r_err    <= 1'b0;
                  r_tcnt   <= '0;
                  r_busy   <= 1'b1;
                  r_ram_se <= 1'b1;
               end
            end
            ST_SEL: begin
               r_wcnt  <= '0;
               r_rdy   <= 1'b1;
               r_phase <= PH_XFER;
               r_state <= ST_WRITE;
            end
            ST_WRITE: begin
               case (r_phase)
                  PH_XFER: begin
                     if (bus.val && r_rdy) begin
                        r_ram_we <= 1'b1;
                        r_ram_d  <= bus.dat;
                        r_wcnt   <= r_wcnt + RAM_A_W'(1);
                        if (r_wcnt == WCNT_LAST) begin
                           r_rdy   <= 1'b0;
                           r_phase <= PH_FLUSH;
                           if (!bus.last) r_err <= 1'b1;
                        end else if (bus.last) begin
                           r_rdy   <= 1'b0;
                           r_phase <= PH_PAD;
                           r_err   <= 1'b1;
                        end
                     end else begin
                        r_ram_we <= 1'b0;
                     end
                  end
                  PH_PAD: begin
                     // zero fill keeps the receiver address aligned to DEPTH
                     r_ram_we <= 1'b1;
                     r_ram_d  <= '0;
                     r_wcnt   <= r_wcnt + RAM_A_W'(1);
                     if (r_wcnt == WCNT_LAST) r_phase <= PH_FLUSH;
                  end
                  PH_FLUSH: begin
                     r_ram_we <= 1'b0;
                     r_phase  <= PH_GAP;
                  end
                  default: begin
                     r_tcnt <= r_tcnt + TCNT_W'(1);
                     if (r_tcnt == TCNT_LAST) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state  <= ST_SEL;
                        r_ram_se <= 1'b1;
                     end
                  end
               endcase
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rdy    = r_rdy;
   assign bus.ram_d  = r_ram_d;
   assign bus.ram_we = r_ram_we;
   assign bus.ram_se = r_ram_se;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_err      = r_err;

endmodule

// File: tb/tb_accum_mult_mod_ram_loader.sv
// Scoreboard bench for the reduction-RAM loader: small config (4-word tables, 2 tables).
module tb_accum_mult_mod_ram_loader;

   localparam int RAM_A_W  = 2;
   localparam int RAM_D_W  = 32;
   localparam int NUM_RAMS = 2;
   localparam int DEPTH    = 4;

   logic clk;
   logic rst_n;
   logic start;
   logic busy, done, err;

   accum_mult_mod_ram_loader_if #(.RAM_D_W(RAM_D_W)) bus ();

   accum_mult_mod_ram_loader #(
      .RAM_A_W (RAM_A_W),
      .RAM_D_W (RAM_D_W),
      .NUM_RAMS(NUM_RAMS)
   ) dut (
      .i_clk  (clk),
      .i_rst  (rst_n),
      .i_start(start),
      .o_busy (busy),
      .o_done (done),
      .o_err  (err),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];
   int  mcnt      = 0;
   bit  model_err = 1'b0;
   bit  prev_acc  = 1'b0;
   int  cyc       = 0;
   int  last_we_cyc = 0;
   bit  have_we   = 1'b0;
   int  se_cnt    = 0;
   int  we_cnt    = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Monitor and scoreboard: outputs compared first, then this cycle's transfer modelled.
   always @(negedge clk) begin
      logic [31:0] e;
      cyc++;
      if (!rst_n) begin
         prev_acc = 1'b0;
      end else begin
         if (prev_acc) chk("lat_we", 32'(bus.ram_we), 32'd1);
         if (bus.ram_we) begin
            we_cnt++;
            last_we_cyc = cyc;
            have_we = 1'b1;
            chk("q_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("ram_d", bus.ram_d, e);
            end
         end
         if (bus.ram_se) begin
            se_cnt++;
            chk("se_we_excl", 32'(bus.ram_we), 32'd0);
            if (have_we) chk("se_gap", 32'((cyc - last_we_cyc) >= 2), 32'd1);
         end
         prev_acc = bus.val && bus.rdy;
         if (prev_acc) begin
            exp_q.push_back(bus.dat);
            if (bus.last && mcnt != DEPTH - 1) model_err = 1'b1;
            if (!bus.last && mcnt == DEPTH - 1) model_err = 1'b1;
            if (bus.last && mcnt < DEPTH - 1) begin
               for (int k = mcnt + 1; k < DEPTH; k++) exp_q.push_back(32'd0);
               mcnt = 0;
            end else begin
               mcnt = (mcnt == DEPTH - 1) ? 0 : mcnt + 1;
            end
         end
      end
   end

   task automatic begin_seq();
      se_cnt = 0;
      we_cnt = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      model_err = 1'b0;
      @(negedge clk);
      chk("busy_on", 32'(busy), 32'd1);
      chk("err_clr", 32'(err), 32'd0);
   endtask

   task automatic send_word(input logic [31:0] d, input bit l);
      int n = 0;
      bus.val  = 1'b1;
      bus.dat  = d;
      bus.last = l;
      @(negedge clk);
      while (!bus.rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rdy_wait", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      bus.val  = 1'b0;
      bus.last = 1'b0;
   endtask

   task automatic send_table(input logic [31:0] base, input bit last_ok, input bit gaps);
      for (int i = 0; i < DEPTH; i++) begin
         send_word(base + 32'(i), last_ok && (i == DEPTH - 1));
         if (gaps) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 200);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_err"}, 32'(err), 32'(model_err));
      @(negedge clk);
      chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
      chk({tag, "_busy_off"}, 32'(busy), 32'd0);
      chk({tag, "_se_cnt"}, 32'(se_cnt), 32'(NUM_RAMS));
      chk({tag, "_we_cnt"}, 32'(we_cnt), 32'(NUM_RAMS * DEPTH));
      chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      bus.val  = 1'b0;
      bus.dat  = '0;
      bus.last = 1'b0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdy", 32'(bus.rdy), 32'd0);
      chk("rst_we", 32'(bus.ram_we), 32'd0);
      chk("rst_se", 32'(bus.ram_se), 32'd0);
      chk("rst_ram_d", bus.ram_d, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // back-to-back words 0x10..0x17
      begin_seq();
      send_table(32'h10, 1'b1, 1'b0);
      send_table(32'h14, 1'b1, 1'b0);
      wait_done("b2b");

      // i_val toggling every cycle
      @(posedge clk); #1;
      begin_seq();
      send_table(32'h10, 1'b1, 1'b1);
      send_table(32'h14, 1'b1, 1'b1);
      wait_done("gaps");

      // early i_last on word 2 of table 0: expect 0xA, 0xB, 0, 0
      @(posedge clk); #1;
      begin_seq();
      send_word(32'hA, 1'b0);
      send_word(32'hB, 1'b1);
      chk("early_err", 32'(err), 32'd1);
      send_table(32'h20, 1'b1, 1'b0);
      chk("early_sticky", 32'(err), 32'd1);
      wait_done("early");

      // missing i_last on table 0 word 4
      @(posedge clk); #1;
      begin_seq();
      send_table(32'h40, 1'b0, 1'b0);
      send_table(32'h44, 1'b1, 1'b0);
      wait_done("nolast");
      @(posedge clk); #1;
      begin_seq();
      send_table(32'h50, 1'b1, 1'b0);
      send_table(32'h54, 1'b1, 1'b0);
      wait_done("reload");

      // asynchronous reset in the middle of table 1
      @(posedge clk); #1;
      begin_seq();
      send_table(32'h30, 1'b1, 1'b0);
      send_word(32'h34, 1'b0);
      send_word(32'h35, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_we", 32'(bus.ram_we), 32'd0);
      chk("arst_ram_d", bus.ram_d, 32'd0);
      chk("arst_rdy", 32'(bus.rdy), 32'd0);
      chk("arst_err", 32'(err), 32'd0);
      exp_q.delete();
      mcnt = 0;
      model_err = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_rdy", 32'(bus.rdy), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      begin_seq();
      send_table(32'h10, 1'b1, 1'b0);
      send_table(32'h14, 1'b1, 1'b0);
      wait_done("after_rst");

      // i_start while busy is ignored
      @(posedge clk); #1;
      begin_seq();
      send_word(32'h60, 1'b0);
      send_word(32'h61, 1'b0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      send_word(32'h62, 1'b0);
      send_word(32'h63, 1'b1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      send_table(32'h64, 1'b1, 1'b0);
      wait_done("start_busy");

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
